cdb_broadcaster: RTL and testbench
==================================

// Module: cdb_broadcaster
// PURPOSE
//  Transmit side of the Common Data Bus. Collects completed results (physical
//  tag + value) from the functional units (ALU, FP1, FP2, LD, ST) in per-FU
//  completion FIFOs. Arbitrates round-robin and broadcasts one result per cycle
//  on the CDB that the reservation stations, map table and ROB snoop.
//  Sits between FU writeback and the CDB consumers; owns the CDB driver.
// PARAMETERS
//  NUM_FU      5   number of FU completion ports (0=ALU,1=FP1,2=FP2,3=LD,4=ST)
//  TAG_W       6   physical register tag width
//  DATA_W      32  result value width
//  FIFO_DEPTH  2   entries per FU completion FIFO (>=1)
// PORTS
//  clock     in   1                 system clock, rising edge
//  reset     in   1                 async, active-low (0 = reset asserted)
//  squash    in   1                 mispredict flush; discards all pending results
//  fu_req    in   NUM_FU            FU i presents a completed result this cycle
//  fu_tag    in   NUM_FU*TAG_W      FU i destination tag, slice [i*TAG_W +: TAG_W]
//  fu_data   in   NUM_FU*DATA_W     FU i result, slice [i*DATA_W +: DATA_W]
//  fu_ready  out  NUM_FU            FU i FIFO can accept (count_i < FIFO_DEPTH)
//  cdb_valid out  1                 broadcast valid (registered)
//  cdb_tag   out  TAG_W             broadcast tag (registered)
//  cdb_data  out  DATA_W            broadcast value (registered)
//  cdb_fu    out  $clog2(NUM_FU)    index of FU whose result is on the bus
// BEHAVIOUR
//  - Reset (reset==0, async): FIFOs empty, RR pointer=0, cdb_valid=0,
//    cdb_tag=0, cdb_data=0, cdb_fu=0; fu_ready all 1 on the first cycle after release.
//  - Enqueue: at posedge, if fu_req[i] && fu_ready[i], push {tag,data} into FIFO i.
//    fu_ready is from count at start of cycle; full FIFO never enqueues, even if it
//    also dequeues in that cycle. fu_req while !fu_ready: dropped, assertion fires.
//  - Arbitration (combinational on FIFO heads): candidates = non-empty FIFOs;
//    winner = first candidate at or after rr_ptr (wrap NUM_FU-1 -> 0).
//    On grant: pop winner, rr_ptr <= (winner+1) mod NUM_FU. No candidates: rr_ptr holds.
//  - Output register: at posedge, cdb_valid <= grant; on grant cdb_tag/data/fu <= winner
//    head; without grant cdb_tag/data/fu hold their value, cdb_valid=0.
//  - Latency (no bypass): request sampled at edge k, on CDB after edge k+1 at earliest.
//  - Exactly one broadcast per cycle max; FIFO order preserved per FU.
//  - Throughput: sustained 1 result/cycle with any mix of requesters; no
//    starvation: any non-empty FIFO is granted within NUM_FU cycles.
//  - squash: at posedge all FIFOs cleared, cdb_valid <= 0, rr_ptr <= 0; fu_req in
//    the same cycle is dropped; squash wins over every simultaneous event.
//  - Async reset mid-broadcast: cdb_valid drops immediately, pending results lost.
// CONFIGURATION
//  CDB_BYPASS_EN defined: an FU whose FIFO is empty may compete with its live
//    fu_req (when fu_ready); if it wins, the result goes straight to the output
//    register at edge k (1-cycle latency) and is not written to the FIFO.
//    Head entries of other FUs still take rr order; bypass is only a candidate
//    at its own rr position.
//  Undefined: all results pass through the FIFO; minimum latency 2 cycles.
// TESTING
//  1 Reset: hold reset=0 with fu_req=5'b11111 -> cdb_valid=0, tag/data=0; after
//    release fu_ready=5'b11111, cdb_valid stays 0 with no requests.
//  2 Single result: ALU req tag=6'h0A data=32'hDEADBEEF at edge k -> cdb_valid=1,
//    cdb_tag=0A, cdb_data=DEADBEEF, cdb_fu=0 after edge k+1 (k with CDB_BYPASS_EN), 1 cycle only.
//  3 Contention: all 5 FUs req tags 1..5 same edge -> 5 consecutive broadcasts,
//    cdb_fu order 0,1,2,3,4, no gaps, no duplicates.
//  4 Back-pressure: FP1 reqs tags 7,8,9 on 3 consecutive cycles while LD keeps
//    bus busy -> fu_ready[1]=0 after 2 queued (depth 2), tag 9 dropped + assertion;
//    7 before 8 on the bus.
//  5 Fairness/wrap: FUs 3,4 continuously req while rr_ptr=4 -> grants 4,3,4,3...,
//    rr_ptr wraps 4->0.
//  6 Squash: 3 results pending + new ST req, squash=1 one cycle -> cdb_valid=0
//    next cycle, no pending tag ever broadcast, fu_ready=5'b11111.

Source files
------------

// File: rtl/cdb_broadcaster_if.sv
// FU completion ports and the CDB broadcast bus of cdb_broadcaster.
// slave = broadcaster side, master = FU writeback / bus consumer side.
interface cdb_broadcaster_if #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]        fu_req;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [FU_W-1:0]          cdb_fu;

    modport slave (
        input  fu_req, fu_tag, fu_data,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_fu
    );

    modport master (
        output fu_req, fu_tag, fu_data,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_fu
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common Data Bus transmitter: per-FU completion FIFOs, round-robin arbiter, registered CDB.
// Optional CDB_BYPASS_EN: an FU with an empty FIFO competes with its live result.
module cdb_broadcaster #(
    parameter int NUM_FU     = 5,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    cdb_broadcaster_if.slave      bus
);
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem    [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_FU];
    logic [PTR_W-1:0]  wr_ptr [NUM_FU];
    logic [CNT_W-1:0]  count  [NUM_FU];
    entry_t            head   [NUM_FU];
    entry_t            live   [NUM_FU];
    logic [FU_W-1:0]   rr_ptr;
    logic [NUM_FU-1:0] fu_ready;
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    int                arb_idx;

    logic              vld_p0;
    logic [FU_W-1:0]   win_fu_p0;
    entry_t            win_p0;

    logic              cdb_valid_q;
    logic [FU_W-1:0]   cdb_fu_q;
    entry_t            cdb_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = count[i] < CNT_W'(FIFO_DEPTH);
            head[i]     = mem[i][rd_ptr[i]];
            live[i]     = {bus.fu_tag[i*TAG_W +: TAG_W], bus.fu_data[i*DATA_W +: DATA_W]};
`ifdef CDB_BYPASS_EN
            cand[i]     = (count[i] != '0) || bus.fu_req[i];
`else
            cand[i]     = (count[i] != '0);
`endif
        end
    end

    // Stage p0: round-robin pick, first candidate at or after rr_ptr
    always_comb begin
        vld_p0    = 1'b0;
        win_fu_p0 = '0;
        arb_idx   = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NUM_FU) arb_idx = arb_idx - NUM_FU;
            if (!vld_p0 && cand[arb_idx]) begin
                vld_p0    = 1'b1;
                win_fu_p0 = FU_W'(arb_idx);
            end
        end
`ifdef CDB_BYPASS_EN
        win_p0 = (count[win_fu_p0] == '0) ? live[win_fu_p0] : head[win_fu_p0];
`else
        win_p0 = head[win_fu_p0];
`endif
    end

    // A winning FU with an empty FIFO is a bypass; its result must not also be queued.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i]  = vld_p0 && (win_fu_p0 == FU_W'(i)) && (count[i] != '0);
            push[i] = bus.fu_req[i] && fu_ready[i] &&
                      !(vld_p0 && (win_fu_p0 == FU_W'(i)) && (count[i] == '0));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else if (squash) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            if (vld_p0)
                rr_ptr <= (win_fu_p0 == FU_W'(NUM_FU - 1)) ? '0 : win_fu_p0 + 1'b1;
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++)
            if (push[i] && !squash) mem[i][wr_ptr[i]] <= live[i];
    end

    // Stage p1: registered CDB driver
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid_q <= 1'b0;
            cdb_fu_q    <= '0;
            cdb_q       <= '0;
        end else if (squash) begin
            cdb_valid_q <= 1'b0;
        end else begin
            cdb_valid_q <= vld_p0;
            if (vld_p0) begin
                cdb_fu_q <= win_fu_p0;
                cdb_q    <= win_p0;
            end
        end
    end

    assign bus.fu_ready  = fu_ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_q.tag;
    assign bus.cdb_data  = cdb_q.data;
    assign bus.cdb_fu    = cdb_fu_q;

    always @(posedge clock) begin
        if (reset && !squash)
            for (int i = 0; i < NUM_FU; i++)
                assert (!(bus.fu_req[i] && !fu_ready[i]))
                else $warning("cdb_broadcaster: FU %0d result dropped, completion FIFO full", i);
    end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed scoreboard bench for cdb_broadcaster (default build, no bypass).
module tb_cdb_broadcaster;
    localparam int NUM_FU = 5;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic squash = 1'b0;

    cdb_broadcaster_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_broadcaster #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          fu;
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   fu_order[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mon_idx;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        bus.fu_req = '0;
    endtask

    task automatic drive(input int fu, input logic [5:0] tag, input logic [31:0] data, input bit expected);
        bus.fu_req[fu] = 1'b1;
        bus.fu_tag[fu*TAG_W +: TAG_W] = tag;
        bus.fu_data[fu*DATA_W +: DATA_W] = data;
        if (expected) sb.push_back('{fu, tag, data});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
        tick();
        tick();
    endtask

    // Output monitor: every broadcast must be the oldest outstanding result of its FU.
    always begin
        @(posedge clock);
        #1;
        if (bus.cdb_valid === 1'b1) begin
            mon_idx = -1;
            foreach (sb[j])
                if (mon_idx < 0 && sb[j].fu == int'(bus.cdb_fu)) mon_idx = j;
            check("sb_hit", {63'b0, mon_idx >= 0}, 64'd1);
            if (mon_idx >= 0) begin
                check("cdb_tag", 64'(bus.cdb_tag), 64'(sb[mon_idx].tag));
                check("cdb_data", 64'(bus.cdb_data), 64'(sb[mon_idx].data));
                sb.delete(mon_idx);
            end
            if (fu_order.size() > 0)
                check("rr_order", 64'(bus.cdb_fu), 64'(fu_order.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.fu_req  = '0;
        bus.fu_tag  = '0;
        bus.fu_data = '0;

        // Reset held with all FUs requesting
        for (int i = 0; i < NUM_FU; i++) drive(i, 6'(i + 40), $urandom, 1'b0);
        repeat (3) tick();
        check("reset_valid", 64'(bus.cdb_valid), 64'd0);
        check("reset_tag", 64'(bus.cdb_tag), 64'd0);
        check("reset_data", 64'(bus.cdb_data), 64'd0);
        check("reset_fu", 64'(bus.cdb_fu), 64'd0);
        idle();
        tick();
        reset = 1'b1;
        #1;
        check("ready_after_reset", 64'(bus.fu_ready), 64'h1f);
        tick();
        tick();
        check("idle_valid", 64'(bus.cdb_valid), 64'd0);

        // All five FUs at once: back-to-back broadcasts in FU order
        for (int i = 0; i < NUM_FU; i++) begin
            drive(i, 6'(i + 1), 32'hC0DE_0000 + 32'(i), 1'b1);
            fu_order.push_back(i);
        end
        tick();
        idle();
        check("contend_lat", 64'(bus.cdb_valid), 64'd0);
        for (int c = 0; c < NUM_FU; c++) begin
            tick();
            check("contend_busy", 64'(bus.cdb_valid), 64'd1);
        end
        tick();
        check("contend_end", 64'(bus.cdb_valid), 64'd0);
        drain("contend_drain");

        // Single ALU result: visible after the second edge, for one cycle
        drive(0, 6'h0A, 32'hDEADBEEF, 1'b1);
        tick();
        idle();
        check("single_lat", 64'(bus.cdb_valid), 64'd0);
        tick();
        check("single_valid", 64'(bus.cdb_valid), 64'd1);
        check("single_tag", 64'(bus.cdb_tag), 64'h0A);
        check("single_data", 64'(bus.cdb_data), 64'hDEADBEEF);
        check("single_fu", 64'(bus.cdb_fu), 64'd0);
        tick();
        check("single_once", 64'(bus.cdb_valid), 64'd0);
        drain("single_drain");

        // Back-pressure on FP1 while LD/ST keep the bus busy
        drive(3, 6'h30, $urandom, 1'b1);
        drive(4, 6'h20, $urandom, 1'b1);
        tick();
        idle();
        drive(3, 6'h31, $urandom, 1'b1);
        drive(4, 6'h21, $urandom, 1'b1);
        drive(1, 6'h07, 32'h0000_0007, 1'b1);
        tick();
        idle();
        drive(3, 6'h32, $urandom, 1'b1);
        drive(1, 6'h08, 32'h0000_0008, 1'b1);
        tick();
        check("bp_ready_fp1", 64'(bus.fu_ready[1]), 64'd0);
        idle();
        drive(1, 6'h09, 32'h0000_0009, 1'b0);
        tick();
        idle();
        drain("bp_drain");

        // Park rr_ptr at 4: a lone LD grant leaves it pointing at ST
        drive(3, 6'h33, $urandom, 1'b1);
        tick();
        idle();
        drain("rr_setup_drain");

        // LD and ST both streaming: grants alternate 4,3,... across the wrap
        for (int k = 0; k < 3; k++) begin
            fu_order.push_back(4);
            fu_order.push_back(3);
        end
        for (int c = 0; c < 8; c++) begin
            idle();
            if (bus.fu_ready[3]) drive(3, 6'(6'h10 + c), $urandom, 1'b1);
            if (bus.fu_ready[4]) drive(4, 6'(6'h28 + c), $urandom, 1'b1);
            tick();
        end
        idle();
        drain("wrap_drain");
        check("wrap_order_done", 64'(fu_order.size()), 64'd0);

        // Squash with pending results and a simultaneous ST request
        drive(0, 6'h11, $urandom, 1'b0);
        drive(1, 6'h12, $urandom, 1'b0);
        drive(2, 6'h13, $urandom, 1'b0);
        drive(3, 6'h14, $urandom, 1'b0);
        tick();
        idle();
        drive(4, 6'h15, $urandom, 1'b0);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        idle();
        check("squash_valid", 64'(bus.cdb_valid), 64'd0);
        check("squash_ready", 64'(bus.fu_ready), 64'h1f);
        repeat (4) begin
            tick();
            check("squash_quiet", 64'(bus.cdb_valid), 64'd0);
        end
        drive(2, 6'h3F, 32'h1234_5678, 1'b1);
        tick();
        idle();
        tick();
        check("post_squash_valid", 64'(bus.cdb_valid), 64'd1);
        drain("post_squash_drain");

        // Asynchronous reset while a result is on the bus; FP1 result is lost
        drive(0, 6'h21, 32'hA5A5_0001, 1'b1);
        drive(1, 6'h22, 32'hA5A5_0002, 1'b0);
        tick();
        idle();
        tick();
        check("arst_pre", 64'(bus.cdb_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("arst_valid", 64'(bus.cdb_valid), 64'd0);
        check("arst_tag", 64'(bus.cdb_tag), 64'd0);
        tick();
        reset = 1'b1;
        repeat (4) begin
            tick();
            check("arst_quiet", 64'(bus.cdb_valid), 64'd0);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("order_empty", 64'(fu_order.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
